// File: rtl/shifter_pkg.sv
// shifter_pkg: shared shift-count type and per-stage shift amount for the barrel shifter.
package shifter_pkg;
  localparam int SHIFT_W = 6;
  typedef logic [SHIFT_W-1:0] shamt_t;
  function automatic int stage_shift(input int k);
    return 1 << k;
  endfunction
endpackage

// File: rtl/shifter_if.sv
// shifter_if: operand/result bus of the registered arithmetic right shifter.
interface shifter_if #(parameter int BIT_WIDTH = 8);
  import shifter_pkg::*;
  logic in_valid;
  logic [BIT_WIDTH-1:0] x_in;
  shamt_t shift_by_in;
  logic [BIT_WIDTH-1:0] y_out;
  logic out_valid;
  modport master(output in_valid, x_in, shift_by_in, input y_out, out_valid);
  modport slave(input in_valid, x_in, shift_by_in, output y_out, out_valid);
endinterface

// File: rtl/shifter_stage.sv
// shifter_stage: one barrel level, arithmetic shift by 2^STAGE when enabled.
// Reports the most significant bit this level would discard, which feeds rounding.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int STAGE = 0
) (
  input  logic [BIT_WIDTH-1:0] data,
  input  logic                 en,
  output logic [BIT_WIDTH-1:0] q,
  output logic                 last_out
);
  localparam int SH = stage_shift(STAGE);
  localparam int LB = (SH < BIT_WIDTH ? SH : BIT_WIDTH) - 1;
  if (SH >= BIT_WIDTH) begin : g_fill
    assign q = en ? {BIT_WIDTH{data[BIT_WIDTH-1]}} : data;
  end else begin : g_shift
    assign q = en ? BIT_WIDTH'($signed(data) >>> SH) : data;
  end
  assign last_out = data[LB];
endmodule

// File: rtl/shifter.sv
// shifter: registered arithmetic right shifter (x >>> n, 1-cycle latency, full throughput).
// Define SHIFTER_ROUND_EN for round-half-up instead of truncation toward -inf.
module shifter
  import shifter_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  shifter_if.slave bus
);
  localparam shamt_t WMAX = shamt_t'(BIT_WIDTH);
  logic [SHIFT_W:0][BIT_WIDTH-1:0] d;
  logic [SHIFT_W:0] r;
  logic [SHIFT_W-1:0] lo;
  logic [BIT_WIDTH-1:0] res;
  assign d[0] = bus.x_in;
  assign r[0] = 1'b0;
  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    shifter_stage #(.BIT_WIDTH(BIT_WIDTH), .STAGE(k)) u_stage (
      .data(d[k]),
      .en(bus.shift_by_in[k]),
      .q(d[k+1]),
      .last_out(lo[k])
    );
    // the highest enabled stage discards bit x[s-1], the rounding bit
    assign r[k+1] = bus.shift_by_in[k] ? lo[k] : r[k];
  end
`ifdef SHIFTER_ROUND_EN
  assign res = d[SHIFT_W] + {{(BIT_WIDTH-1){1'b0}}, r[SHIFT_W] && (bus.shift_by_in <= WMAX)};
`else
  logic unused_round;
  assign unused_round = r[SHIFT_W] ^ (WMAX == '0);
  assign res = d[SHIFT_W];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.y_out <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.y_out <= res;
    end
endmodule

// File: tb/tb_shifter.sv
// tb_shifter: directed vectors with literal expectations plus a per-cycle floor-division model.
module tb_shifter;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] ey = '0;
  logic ev = 1'b0;
  shifter_if #(.BIT_WIDTH(W)) bus();
  shifter #(.BIT_WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input int s);
    longint xi;
    longint q;
    xi = longint'($signed(x));
    if (s == 0) q = xi;
`ifdef SHIFTER_ROUND_EN
    else if (s <= W) q = floor_div(xi + (64'sd1 <<< (s - 1)), 64'sd1 <<< s);
`endif
    else if (s >= W) q = (xi < 0) ? -1 : 0;
    else q = floor_div(xi, 64'sd1 <<< s);
    return q[W-1:0];
  endfunction
  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ey = '0;
      ev = 1'b0;
    end else begin
      ev = bus.in_valid;
      if (bus.in_valid) ey = model(bus.x_in, int'(bus.shift_by_in));
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("model_y", bus.y_out, ey);
      chk("model_v", {7'b0, bus.out_valid}, {7'b0, ev});
    end
  task automatic step(input logic [W-1:0] x, input int s, input logic v, input logic [W-1:0] exp, input string nm);
    @(negedge clk);
    bus.in_valid = v;
    bus.x_in = x;
    bus.shift_by_in = 6'(s);
    @(posedge clk);
    #1;
    chk({nm, "_y"}, bus.y_out, exp);
    chk({nm, "_v"}, {7'b0, bus.out_valid}, {7'b0, v});
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.x_in = '0;
    bus.shift_by_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_y", bus.y_out, 8'h00);
    chk("rst_v", {7'b0, bus.out_valid}, 8'h00);
    rst_n = 1'b1;
    step(8'h80, 0, 1'b1, 8'h80, "neg_s0");
    step(8'h80, 1, 1'b1, 8'hC0, "neg_s1");
    step(8'h80, 2, 1'b1, 8'hE0, "neg_s2");
    step(8'h80, 3, 1'b1, 8'hF0, "neg_s3");
    step(8'h7F, 0, 1'b1, 8'h7F, "pos_s0");
`ifdef SHIFTER_ROUND_EN
    step(8'h7F, 1, 1'b1, 8'h40, "pos_s1");
    step(8'h7F, 4, 1'b1, 8'h08, "pos_s4");
    step(8'h55, 0, 1'b0, 8'h08, "gate");
    step(8'h7F, 7, 1'b1, 8'h01, "pos_s7");
    step(8'h81, 8, 1'b1, 8'h00, "ovr_s8");
    step(8'h03, 1, 1'b1, 8'h02, "rnd_p");
    step(8'hFD, 1, 1'b1, 8'hFF, "rnd_n");
`else
    step(8'h7F, 1, 1'b1, 8'h3F, "pos_s1");
    step(8'h7F, 4, 1'b1, 8'h07, "pos_s4");
    step(8'h55, 0, 1'b0, 8'h07, "gate");
    step(8'h7F, 7, 1'b1, 8'h00, "pos_s7");
    step(8'h81, 8, 1'b1, 8'hFF, "ovr_s8");
    step(8'h03, 1, 1'b1, 8'h01, "rnd_p");
    step(8'hFD, 1, 1'b1, 8'hFE, "rnd_n");
`endif
    step(8'h81, 63, 1'b1, 8'hFF, "ovr_s63");
    step(8'h40, 63, 1'b1, 8'h00, "ovr_pos63");
    step(8'hA6, 5, 1'b1, model(8'hA6, 5), "mix_a");
    step(8'h5B, 3, 1'b1, model(8'h5B, 3), "mix_b");
    step(8'h9C, 2, 1'b1, model(8'h9C, 2), "mix_c");
    @(negedge clk);
    bus.x_in = 8'hC3;
    bus.shift_by_in = 6'd0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", bus.y_out, 8'h00);
    chk("async_rst_v", {7'b0, bus.out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_v", {7'b0, bus.out_valid}, 8'h00);
    step(8'hF0, 2, 1'b1, 8'hFC, "post_rst");
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
